// File: rtl/enh_ds_downsampler_if.sv
// Pixel-in / downsampled-pixel-out stream bundle for enh_ds_downsampler.
// slave is the downsampler side, master is the pixel source / tracer side.
interface enh_ds_downsampler_if;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       enh_ds_ena;
  logic [7:0] enh_ds_row;
  logic [8:0] enh_ds_col;
  logic [7:0] enh_ds_data;

  modport master (
    output pix_valid, pix_data,
    input  enh_ds_ena, enh_ds_row, enh_ds_col, enh_ds_data
  );

  modport slave (
    input  pix_valid, pix_data,
    output enh_ds_ena, enh_ds_row, enh_ds_col, enh_ds_data
  );
endinterface

// File: rtl/enh_ds_downsampler.sv
// 2x2 box-average downsampler: raster pixels in, rounded averages tagged with
// downsampled row/col out. One row-sum line buffer, no backpressure.
module enh_ds_downsampler #(
  parameter int DS_ROWS = 240,
  parameter int DS_COLS = 320
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic                  frame_start,
  enh_ds_downsampler_if.slave   bus,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  drop_err
);

  localparam int         IDX_W    = (DS_COLS > 1) ? $clog2(DS_COLS) : 1;
  localparam logic [9:0] COL_LAST = 10'(2*DS_COLS-1);
  localparam logic [8:0] ROW_LAST = 9'(2*DS_ROWS-1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  typedef struct packed {
    logic [7:0] row;
    logic [8:0] col;
    logic [7:0] data;
  } ds_pix_t;

  state_t     state_q, state_d;
  logic [8:0] in_row;
  logic [9:0] in_col;
  logic [7:0] h_reg;
  logic [8:0] line_buf [DS_COLS];
  ds_pix_t    out_q;
  logic       ena_q, done_q, drop_q, last_q;

  logic       accept, clr, set_drop, clr_drop, done_d;
  logic       wr_en, out_en, is_last;
  logic [8:0] h_sum;
  logic [9:0] sum;
  logic [IDX_W-1:0] idx;

  assign idx     = in_col[IDX_W:1];
  assign h_sum   = {1'b0, h_reg} + {1'b0, bus.pix_data};
  assign sum     = {1'b0, line_buf[idx]} + {1'b0, h_sum} + 10'd2;
  assign is_last = (in_row == ROW_LAST) && (in_col == COL_LAST);
  assign wr_en   = accept & ~in_row[0] & in_col[0];
  assign out_en  = accept &  in_row[0] & in_col[0];

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    clr      = 1'b0;
    set_drop = 1'b0;
    clr_drop = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d  = S_RUN;
          clr      = 1'b1;
          clr_drop = 1'b1;
        end else if (bus.pix_valid) begin
          set_drop = 1'b1;
        end
      end
      S_RUN: begin
        // A restart wins over the pending frame_done of the previous frame.
        if (frame_start) begin
          clr = 1'b1;
        end else if (last_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (bus.pix_valid) begin
          accept = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q <= S_IDLE;
      in_row  <= '0;
      in_col  <= '0;
      h_reg   <= '0;
      out_q   <= '0;
      ena_q   <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      last_q  <= accept & is_last;
      ena_q   <= out_en;
      if (clr_drop)      drop_q <= 1'b0;
      else if (set_drop) drop_q <= 1'b1;
      if (out_en) begin
        out_q.row  <= in_row[8:1];
        out_q.col  <= in_col[9:1];
        out_q.data <= sum[9:2];
      end
      if (clr) begin
        in_row <= '0;
        in_col <= '0;
      end else if (accept) begin
        if (!in_col[0]) h_reg <= bus.pix_data;
        if (in_col == COL_LAST) begin
          in_col <= '0;
          in_row <= (in_row == ROW_LAST) ? 9'd0 : in_row + 9'd1;
        end else begin
          in_col <= in_col + 10'd1;
        end
      end
    end
  end

  // Not reset: every odd-row read follows an even-row write of the same frame.
  always_ff @(posedge s_axi_aclk) begin
    if (wr_en) line_buf[idx] <= h_sum;
  end

  assign bus.enh_ds_ena  = ena_q;
  assign bus.enh_ds_row  = out_q.row;
  assign bus.enh_ds_col  = out_q.col;
  assign bus.enh_ds_data = out_q.data;
  assign frame_done      = done_q;
  assign busy            = (state_q == S_RUN);
  assign drop_err        = drop_q;

endmodule

// File: tb/tb_enh_ds_downsampler.sv
// Directed bench for enh_ds_downsampler on a 4x6 input frame (DS 2x3).
module tb_enh_ds_downsampler;
  logic s_axi_aclk;
  logic s_axi_aresetn;
  logic frame_start;
  logic frame_done;
  logic busy;
  logic drop_err;
  int   checks   = 0;
  int   failures = 0;

  enh_ds_downsampler_if ds_if ();

  enh_ds_downsampler #(.DS_ROWS(2), .DS_COLS(3)) dut (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .frame_start   (frame_start),
    .bus           (ds_if),
    .frame_done    (frame_done),
    .busy          (busy),
    .drop_err      (drop_err)
  );

  initial begin
    s_axi_aclk = 1'b0;
    forever #5 s_axi_aclk = ~s_axi_aclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change after the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic beat(input logic [7:0] d);
    @(negedge s_axi_aclk);
    ds_if.pix_valid = 1'b1;
    ds_if.pix_data  = d;
    @(posedge s_axi_aclk);
    #1;
    ds_if.pix_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic with_beat);
    @(negedge s_axi_aclk);
    frame_start     = 1'b1;
    ds_if.pix_valid = with_beat;
    ds_if.pix_data  = 8'd77;
    @(posedge s_axi_aclk);
    #1;
    frame_start     = 1'b0;
    ds_if.pix_valid = 1'b0;
  endtask

  function automatic int pix_of(input int mode, input int r, input int c);
    case (mode)
      0:       return 100;
      1:       return (r*61 + c*37 + 5) % 256;
      default: return 255;
    endcase
  endfunction

  // Feeds one 24-beat frame (state must already be RUN) and checks every strobe.
  task automatic run_frame(input int mode, input int gap_max);
    for (int k = 0; k < 24; k++) begin
      int r = k / 6;
      int c = k % 6;
      int s;
      if (gap_max > 0) begin
        int g = $urandom_range(gap_max, 0);
        repeat (g) begin
          @(posedge s_axi_aclk);
          #1;
          chk("gap_ena", ds_if.enh_ds_ena, 0);
        end
      end
      beat(8'(pix_of(mode, r, c)));
      chk("done_early", frame_done, 0);
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        s = pix_of(mode, r-1, c-1) + pix_of(mode, r-1, c) + pix_of(mode, r, c-1)
          + pix_of(mode, r, c) + 2;
        chk("strobe_ena", ds_if.enh_ds_ena, 1);
        chk("strobe_row", ds_if.enh_ds_row, r / 2);
        chk("strobe_col", ds_if.enh_ds_col, c / 2);
        chk("strobe_data", ds_if.enh_ds_data, s / 4);
      end else begin
        chk("no_strobe", ds_if.enh_ds_ena, 0);
      end
    end
    @(posedge s_axi_aclk);
    #1;
    chk("frame_done", frame_done, 1);
    chk("busy_fall", busy, 0);
    chk("ena_after_last", ds_if.enh_ds_ena, 0);
    chk("row_hold", ds_if.enh_ds_row, 1);
    chk("col_hold", ds_if.enh_ds_col, 2);
  endtask

  // Block (0,0) only, then the frame is left open for the next restart to abort.
  task automatic rnd(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] c, input logic [7:0] d, input int exp);
    pulse_start(1'b0);
    chk("rnd_busy", busy, 1);
    chk("rnd_no_done", frame_done, 0);
    beat(a);
    beat(b);
    repeat (4) beat(8'd0);
    beat(c);
    chk("rnd_pre_ena", ds_if.enh_ds_ena, 0);
    beat(d);
    chk("rnd_ena", ds_if.enh_ds_ena, 1);
    chk(tag, ds_if.enh_ds_data, exp);
  endtask

  initial begin
    frame_start     = 1'b0;
    ds_if.pix_valid = 1'b0;
    ds_if.pix_data  = 8'd0;
    s_axi_aresetn   = 1'b0;
    #1;
    chk("rst_ena", ds_if.enh_ds_ena, 0);
    chk("rst_row", ds_if.enh_ds_row, 0);
    chk("rst_col", ds_if.enh_ds_col, 0);
    chk("rst_data", ds_if.enh_ds_data, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_err, 0);
    @(negedge s_axi_aclk);
    s_axi_aresetn = 1'b1;

    // unarmed input, then a beat coincident with frame_start
    repeat (3) begin
      beat(8'd50);
      chk("idle_ena", ds_if.enh_ds_ena, 0);
    end
    chk("drop_set", drop_err, 1);
    chk("idle_busy", busy, 0);
    pulse_start(1'b1);
    chk("drop_clr", drop_err, 0);
    chk("arm_busy", busy, 1);
    run_frame(1, 0);

    // restart in the frame_done cycle, constant frame
    pulse_start(1'b0);
    chk("restart_busy", busy, 1);
    chk("restart_done_low", frame_done, 0);
    run_frame(0, 0);

    // gapped input
    pulse_start(1'b0);
    run_frame(0, 5);
    pulse_start(1'b0);
    run_frame(1, 5);

    // rounding on block (0,0); each restart aborts the previous one
    rnd("rnd_0123", 8'd0, 8'd1, 8'd2, 8'd3, 2);
    rnd("rnd_1000", 8'd1, 8'd0, 8'd0, 8'd0, 0);
    rnd("rnd_1100", 8'd1, 8'd1, 8'd0, 8'd0, 1);
    rnd("rnd_255", 8'd255, 8'd255, 8'd255, 8'd255, 255);

    // abort frame A after 10 beats, then a full frame B
    pulse_start(1'b0);
    for (int k = 0; k < 10; k++) beat(8'(k * 9));
    pulse_start(1'b0);
    chk("abort_no_done", frame_done, 0);
    chk("abort_busy", busy, 1);
    run_frame(1, 0);
    @(posedge s_axi_aclk);
    #1;
    chk("done_single", frame_done, 0);

    // asynchronous reset mid-frame, between clock edges
    pulse_start(1'b0);
    for (int k = 0; k < 8; k++) beat(8'(pix_of(2, k / 6, k % 6)));
    chk("pre_rst_ena", ds_if.enh_ds_ena, 1);
    #2;
    s_axi_aresetn = 1'b0;
    #1;
    chk("arst_ena", ds_if.enh_ds_ena, 0);
    chk("arst_row", ds_if.enh_ds_row, 0);
    chk("arst_col", ds_if.enh_ds_col, 0);
    chk("arst_data", ds_if.enh_ds_data, 0);
    chk("arst_done", frame_done, 0);
    chk("arst_busy", busy, 0);
    chk("arst_drop", drop_err, 0);
    @(negedge s_axi_aclk);
    s_axi_aresetn = 1'b1;
    repeat (3) begin
      beat(8'd200);
      chk("post_rst_ena", ds_if.enh_ds_ena, 0);
    end
    chk("post_rst_drop", drop_err, 1);
    chk("post_rst_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
